harris_line_scheduler: RTL
==========================

Name: harris_line_scheduler

Overview:
- Sequences pixel-line delivery from an upstream frame stream into the 7-line-buffer window generator (imageControl) of the Harris corner pipeline.
- Prefills the line buffers, then releases exactly one new line per line-done interrupt from the window generator.
- Appends zero padding lines so the last window rows flush, counts interrupts and signals frame completion.

Parameters:
- IMG_W, 480, pixels per line.
- IMG_H, 480, lines per frame.
- LB_COUNT, 7, line buffers in the window generator (prefill depth in lines).
- WIN_H, 6, window height in rows.
- PAD_LINES, 5, zero lines appended after the last real line (WIN_H-1).
- TO_CYCLES, 65535, watchdog limit (optional feature only).

Ports:
- i_clk  in  1  clock, all logic on rising edge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_start  in  1  one-cycle frame start pulse.
- i_s_data  in  8  upstream pixel.
- i_s_valid  in  1  upstream pixel valid.
- o_s_ready  out  1  upstream ready; a transfer occurs when i_s_valid & o_s_ready.
- o_pixel_data  out  8  pixel to the window generator.
- o_pixel_data_valid  out  1  pixel strobe to the window generator (no backpressure).
- i_intr  in  1  line-done pulse from the window generator.
- o_busy  out  1  frame in progress.
- o_frame_done  out  1  one-cycle pulse at frame end.
- o_line_cnt  out  clog2(IMG_H+PAD_LINES+1)  lines emitted this frame (real + pad).
- o_err  out  1  sticky error flag, cleared by i_start.

Behaviour:
- Reset (async, i_rst_n=0): state IDLE; all counters 0; all outputs 0.
- Reset mid-frame aborts immediately; no partial line is resumed.
- Totals: TOTAL = IMG_H+PAD_LINES lines emitted; EXP_INTR = TOTAL-WIN_H+1 interrupts expected.
- States:
  - IDLE: i_start -> PREFILL; clear line/intr/credit counters and o_err.
  - PREFILL: emit lines until min(LB_COUNT,TOTAL) lines are out, then -> WAIT.
  - WAIT: credit>0 and lines<TOTAL -> SEND; consume 1 credit. intr_cnt==EXP_INTR -> DONE.
  - SEND: emit one line, then -> WAIT.
  - DONE: pulse o_frame_done for 1 cycle -> IDLE.
- o_busy=1 in every state except IDLE.
- Line emission:
  - Real line (line index < IMG_H): o_s_ready=1 only in PREFILL/SEND.
  - Each accepted pixel appears registered on o_pixel_data with o_pixel_data_valid=1 one cycle later (latency 1).
  - Pad line: o_s_ready=0; emit 0x00 with valid=1 every cycle for IMG_W cycles.
- Counters:
  - Column counter wraps at IMG_W-1 and increments o_line_cnt.
  - Line boundary: if a line ends in PREFILL and the next line is within the prefill count, stay in PREFILL.
- Credits:
  - Each i_intr adds 1 credit, 3-bit saturating; i_intr is accepted in any non-IDLE state, including mid-line.
  - i_intr and a credit consume in the same cycle leave the credit unchanged.
  - Saturation or intr_cnt exceeding EXP_INTR sets o_err.
  - Every i_intr also increments intr_cnt.
- Errors: i_start while busy is ignored and sets o_err. i_intr in IDLE is ignored.
- Credits remaining after all TOTAL lines are emitted are discarded.

Optional Feature:
- Macro HARRIS_SCHED_WATCHDOG_EN.
- When defined: a counter runs in WAIT and resets on i_intr. On reaching TO_CYCLES it sets o_err and forces DONE, pulsing o_frame_done.
- When undefined: no counter exists; WAIT waits indefinitely; TO_CYCLES is unused.

Decomposition:
- Package harris_pkg holds the state enum (IDLE, PREFILL, WAIT, SEND, DONE), the pixel width constant (8) and the clog2-derived counter width helpers.
- One sub-module, harris_line_emitter: column counter, pad/real mux, output register, and line_done pulse.
- The FSM, credits and interrupt counting stay in the top level.

Test Plan:
- Nominal frame (IMG_W=8, IMG_H=12, PAD_LINES=5, upstream always valid), i_start, then i_intr 8 cycles after each window-read window:
  - Exactly 56 pixels out before the first intr, then 8 per credit.
  - Lines 12-16 are all 0x00.
  - EXP_INTR=12; o_frame_done pulses 1 cycle after the 12th intr; o_line_cnt=17.
- Upstream stalls (i_s_valid toggles 50%): output stream equals the input sequence in order; no valid while stalled on a real line.
- Three i_intr pulses during a SEND line: credit=3, three back-to-back lines follow without gaps beyond 1 cycle; o_err=0.
- i_intr on the same cycle the FSM consumes a credit: credit count is unchanged.
- Eight i_intr with no line progress: saturation sets o_err.
- i_rst_n low mid-SEND (async, between clock edges):
  - Outputs are 0 immediately.
  - A new i_start replays the frame from line 0.
- Watchdog build (TO_CYCLES=100) with no intr after prefill: o_err=1 and o_frame_done at WAIT entry + 100 cycles. Without the macro, o_busy stays high.

Source files
------------

// File: rtl/harris_pkg.sv
// Shared types and width helpers for the Harris line scheduler.
package harris_pkg;

  localparam int PIX_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    PREFILL,
    WAIT,
    SEND,
    DONE
  } state_t;

  // Bits needed to hold any value in 0..max_val.
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/harris_line_emitter.sv
// Emits one line at a time: passes upstream pixels through a one-cycle register,
// or generates zero pixels on pad lines, and flags the last pixel of each line.
module harris_line_emitter
  import harris_pkg::*;
#(
  parameter int IMG_W = 480
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_active,
  input  logic             i_pad,
  input  logic [PIX_W-1:0] i_s_data,
  input  logic             i_s_valid,
  output logic             o_s_ready,
  output logic [PIX_W-1:0] o_pixel_data,
  output logic             o_pixel_data_valid,
  output logic             o_line_done
);

  localparam int COL_W = cnt_w(IMG_W - 1);

  logic [COL_W-1:0] r_col;
  logic [PIX_W-1:0] r_data;
  logic             r_valid;
  logic             w_beat;
  logic             w_last;

  // Pad lines never stall: a zero pixel goes out every active cycle.
  assign o_s_ready   = i_active & ~i_pad;
  assign w_beat      = i_active & (i_pad | i_s_valid);
  assign w_last      = (r_col == COL_W'(IMG_W - 1));
  assign o_line_done = w_beat & w_last;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_col   <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
    end else begin
      if (w_beat) begin
        r_col <= w_last ? '0 : r_col + COL_W'(1);
      end
      r_valid <= w_beat;
      r_data  <= (w_beat & ~i_pad) ? i_s_data : '0;
    end
  end

  assign o_pixel_data       = r_data;
  assign o_pixel_data_valid = r_valid;

endmodule

// File: rtl/harris_line_scheduler.sv
// Line scheduler feeding the 7-line window generator: prefill, one line per credit,
// zero pad lines, frame completion. Define HARRIS_SCHED_WATCHDOG_EN for the WAIT watchdog.
module harris_line_scheduler
  import harris_pkg::*;
#(
  parameter int IMG_W     = 480,
  parameter int IMG_H     = 480,
  parameter int LB_COUNT  = 7,
  parameter int WIN_H     = 6,
  parameter int PAD_LINES = 5,
  parameter int TO_CYCLES = 65535
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst_n,
  input  logic                                 i_start,
  input  logic [PIX_W-1:0]                     i_s_data,
  input  logic                                 i_s_valid,
  output logic                                 o_s_ready,
  output logic [PIX_W-1:0]                     o_pixel_data,
  output logic                                 o_pixel_data_valid,
  input  logic                                 i_intr,
  output logic                                 o_busy,
  output logic                                 o_frame_done,
  output logic [cnt_w(IMG_H+PAD_LINES)-1:0]    o_line_cnt,
  output logic                                 o_err
);

  localparam int TOTAL     = IMG_H + PAD_LINES;
  localparam int EXP_INTR  = TOTAL - WIN_H + 1;
  localparam int PREFILL_N = (LB_COUNT < TOTAL) ? LB_COUNT : TOTAL;
  localparam int LINE_W    = cnt_w(TOTAL);
  localparam int INTR_W    = cnt_w(EXP_INTR + 1);

  state_t              r_state;
  state_t              w_state_next;
  logic [LINE_W-1:0]   r_line_cnt;
  logic [2:0]          r_credit;
  logic [INTR_W-1:0]   r_intr_cnt;
  logic                r_err;

  logic w_active;
  logic w_pad;
  logic w_line_done;
  logic w_intr;
  logic w_lines_left;
  logic w_consume;
  logic w_intr_done;
  logic w_sat;
  logic w_over;
  logic w_wd_hit;

  assign w_active     = (r_state == PREFILL) | (r_state == SEND);
  assign w_pad        = (r_line_cnt >= LINE_W'(IMG_H));
  assign w_intr       = i_intr & (r_state != IDLE);
  assign w_lines_left = (r_line_cnt < LINE_W'(TOTAL));
  assign w_consume    = (r_state == WAIT) & (r_credit != 3'd0) & w_lines_left;
  // Look at the post-increment count so DONE follows the final interrupt directly.
  assign w_intr_done  = (r_intr_cnt >= INTR_W'(EXP_INTR)) |
                        (w_intr & (r_intr_cnt == INTR_W'(EXP_INTR - 1)));
  assign w_sat        = w_intr & ~w_consume & w_lines_left & (r_credit == 3'd7);
  assign w_over       = w_intr & (r_intr_cnt >= INTR_W'(EXP_INTR));

  harris_line_emitter #(
    .IMG_W (IMG_W)
  ) u_emitter (
    .i_clk              (i_clk),
    .i_rst_n            (i_rst_n),
    .i_active           (w_active),
    .i_pad              (w_pad),
    .i_s_data           (i_s_data),
    .i_s_valid          (i_s_valid),
    .o_s_ready          (o_s_ready),
    .o_pixel_data       (o_pixel_data),
    .o_pixel_data_valid (o_pixel_data_valid),
    .o_line_done        (w_line_done)
  );

`ifdef HARRIS_SCHED_WATCHDOG_EN
  localparam int WD_W = cnt_w(TO_CYCLES);

  logic [WD_W-1:0] r_wd;

  assign w_wd_hit = (r_state == WAIT) & ~w_intr & (r_wd == WD_W'(TO_CYCLES - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wd <= '0;
    end else if ((r_state != WAIT) || w_intr) begin
      r_wd <= '0;
    end else if (!w_wd_hit) begin
      r_wd <= r_wd + WD_W'(1);
    end
  end
`else
  assign w_wd_hit = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (i_start) w_state_next = PREFILL;
      PREFILL: if (w_line_done && (r_line_cnt == LINE_W'(PREFILL_N - 1))) w_state_next = WAIT;
      WAIT: begin
        if (w_consume)        w_state_next = SEND;
        else if (w_intr_done) w_state_next = DONE;
        else if (w_wd_hit)    w_state_next = DONE;
      end
      SEND:    if (w_line_done) w_state_next = WAIT;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_line_cnt <= '0;
      r_credit   <= '0;
      r_intr_cnt <= '0;
      r_err      <= 1'b0;
    end else if (r_state == IDLE) begin
      if (i_start) begin
        r_line_cnt <= '0;
        r_credit   <= '0;
        r_intr_cnt <= '0;
        r_err      <= 1'b0;
      end
    end else begin
      if (w_line_done) begin
        r_line_cnt <= r_line_cnt + LINE_W'(1);
      end
      // Once every line is out, leftover credits have nothing to buy.
      if (!w_lines_left) begin
        r_credit <= '0;
      end else if (w_intr && !w_consume && (r_credit != 3'd7)) begin
        r_credit <= r_credit + 3'd1;
      end else if (!w_intr && w_consume) begin
        r_credit <= r_credit - 3'd1;
      end
      if (w_intr && !w_over) begin
        r_intr_cnt <= r_intr_cnt + INTR_W'(1);
      end
      r_err <= r_err | i_start | w_sat | w_over | w_wd_hit;
    end
  end

  assign o_busy       = (r_state != IDLE);
  assign o_frame_done = (r_state == DONE);
  assign o_line_cnt   = r_line_cnt;
  assign o_err        = r_err;

endmodule
